dac_pwm_out: RTL
================

Name: dac_pwm_out

Overview:
- Output stage directly downstream of the NCO: consumes its 8-bit offset-binary sample stream and drives a 1-bit DAC pin for an external RC filter.
- Applies centred gain scaling with saturation, then PWM or first-order sigma-delta modulation.
- Issues a one-cycle sample strobe once per 256-cycle modulation period, so upstream sample rate = clk/256.

Parameters:
DATA_W, 8, sample/duty width; modulation period = 2**DATA_W cycles
GAIN_W, 8, gain width, unsigned Q1.7 (128 = unity)

Ports:
clk  in  1  system clock
rst_n  in  1  reset; one clock domain, asynchronous assert, active-low
en_i  in  1  run request, level-sensitive
mode_i  in  1  0 = PWM, 1 = sigma-delta; sampled only at period boundary
sample_i  in  DATA_W  unsigned sample from NCO, 128 = midscale
gain_i  in  GAIN_W  amplitude gain, sampled together with sample_i
sample_strobe_o  out  1  one-cycle pulse: sample_i/gain_i captured this cycle
pwm_o  out  1  registered modulator output
active_o  out  1  high while state is RUN or DRAIN

Behaviour:
- Reset values: pwm_o=0, sample_strobe_o=0, active_o=0. Internal period counter, duty, pending duty, accumulator and mode register all reset to 0; state resets to IDLE. Reset mid-operation forces these values immediately.
- States:
  - IDLE: counter held at 0, pwm_o=0. en_i=1 -> RUN on the next cycle.
  - RUN: counter free-runs 0..255 and wraps.
  - en_i=0 in RUN -> DRAIN. The current period is completed.
  - DRAIN: at counter=255, if en_i=0 -> IDLE; if en_i=1 at any point -> back to RUN with no gap or phase change.
- Strobe: in RUN/DRAIN, sample_strobe_o=1 exactly in cycles where counter==0. Never asserted in IDLE.
- Scale pipeline, 2 cycles after capture:
  - s = sample - 128, signed 9 bits.
  - p = s * gain, signed 17 bits.
  - r = (p >>> 7) + 128, arithmetic shift.
  - Saturate r to 0..255, then register it as pending duty.
- Period boundary (counter 255->0 transition):
  - duty <= pending duty and mode register <= mode_i.
  - A sample captured at the start of period k drives period k+1.
  - The first period after leaving IDLE uses duty = 0, or the last duty if re-entered from DRAIN.
- PWM mode: pwm_o registered from (counter < duty). duty 0 -> constantly low; duty 255 -> high 255 of 256 cycles.
- Sigma-delta mode:
  - Every RUN/DRAIN cycle: {carry, acc} = acc + duty (9-bit sum); pwm_o <= carry.
  - acc is not cleared at boundaries, so each period contains exactly `duty` ones.
- Mode changes mid-period are ignored until the next boundary. acc is cleared on entering IDLE.
- active_o is registered: it rises on the cycle after en_i is seen in IDLE and falls on the cycle after the final counter=255 of DRAIN. pwm_o is 0 in that same cycle.

Decomposition:
- Package dac_pkg holds:
  - state enum {IDLE, RUN, DRAIN}
  - MIDSCALE = 128, UNITY_GAIN = 128, GAIN_FRAC_BITS = 7
  - the saturate helper function
- Sub-module dac_scale: 2-stage registered capture/multiply/offset/saturate pipeline with valid-in (the strobe) and valid-out. Top level holds the FSM, counter and modulators.

Test Plan:
1. Reset, en_i=1, mode=0, gain=128, sample=200 held -> strobe every 256 cycles. From the 2nd period on, pwm_o high for exactly 200 cycles (counter 0..199) per period.
2. Saturation, mode=0:
   - gain=255, sample=255 -> duty 255.
   - gain=255, sample=0 -> duty 0.
   - gain=64, sample=255 -> duty 191.
   - gain=0, any sample -> duty 128.
3. mode=1, sample=128, gain=128 -> pwm_o alternates 1,0,1,0. Then sample=37 -> exactly 37 ones per 256-cycle period, from the period after capture.
4. Toggle mode_i mid-period at counter=100 -> output waveform changes only at the next counter 255->0 boundary.
5. Drain:
   - en_i=0 at counter=100 -> period completes; active_o and pwm_o low from the cycle after counter=255; no further strobes.
   - Repeat with en_i=1 again at counter=180 -> no idle gap, strobe at next counter=0.
6. Assert rst_n=0 mid-run at counter=50 with pwm_o=1 -> pwm_o, strobe and active_o go to 0 without waiting for a clock edge. After release plus en_i=1, the first period has duty 0.

Source files
------------

// File: rtl/dac_pkg.sv
// Shared types and constants for the DAC output stage.
// The saturate helper clamps signed intermediate results into the duty range.
package dac_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } state_e;

    localparam int MIDSCALE       = 128;
    localparam int UNITY_GAIN     = 128;
    localparam int GAIN_FRAC_BITS = 7;

    function automatic int saturate(input int value, input int max_val);
        if (value < 0) begin
            return 0;
        end
        if (value > max_val) begin
            return max_val;
        end
        return value;
    endfunction

endpackage

// File: rtl/dac_pwm_out_if.sv
// Sample handshake between the NCO (master) and the DAC output stage (slave).
// The strobe tells the NCO its sample/gain were captured this cycle.
interface dac_pwm_out_if #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned GAIN_W = 8
);
    logic [DATA_W-1:0] sample;
    logic [GAIN_W-1:0] gain;
    logic              sample_strobe;

    modport master (
        output sample,
        output gain,
        input  sample_strobe
    );

    modport slave (
        input  sample,
        input  gain,
        output sample_strobe
    );
endinterface

// File: rtl/dac_scale.sv
// Two-stage scale pipeline: capture sample/gain on valid_i, then apply centred
// gain, re-offset to midscale and saturate into the duty range.
module dac_scale
    import dac_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned GAIN_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              valid_i,
    input  logic [DATA_W-1:0] sample_i,
    input  logic [GAIN_W-1:0] gain_i,
    output logic              valid_o,
    output logic [DATA_W-1:0] duty_o
);

    logic [DATA_W-1:0] sample_q;
    logic [GAIN_W-1:0] gain_q;
    logic              cap_valid_q;
    int                shifted;
    logic [DATA_W-1:0] sat;

    // Arithmetic shift on a signed int floors negative products.
    always_comb begin
        shifted = ((int'(sample_q) - MIDSCALE) * int'(gain_q)) >>> GAIN_FRAC_BITS;
        sat     = DATA_W'(saturate(shifted + MIDSCALE, (1 << DATA_W) - 1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sample_q    <= '0;
            gain_q      <= '0;
            cap_valid_q <= 1'b0;
            valid_o     <= 1'b0;
            duty_o      <= '0;
        end else begin
            cap_valid_q <= valid_i;
            valid_o     <= cap_valid_q;
            if (valid_i) begin
                sample_q <= sample_i;
                gain_q   <= gain_i;
            end
            if (cap_valid_q) begin
                duty_o <= sat;
            end
        end
    end

endmodule

// File: rtl/dac_pwm_out.sv
// 1-bit DAC output stage: run/drain FSM, modulation-period counter, and a
// PWM or first-order sigma-delta modulator fed by the scale pipeline.
module dac_pwm_out
    import dac_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned GAIN_W = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en_i,
    input  logic          mode_i,
    dac_pwm_out_if.slave  smp,
    output logic          pwm_o,
    output logic          active_o
);

    state_e            state_q;
    logic [DATA_W-1:0] cnt_q;
    logic [DATA_W-1:0] duty_q;
    logic [DATA_W-1:0] pend_q;
    logic [DATA_W-1:0] acc_q;
    logic              mode_q;
    logic              pwm_q;
    logic              active_q;

    logic              strobe;
    logic              period_end;
    logic [DATA_W:0]   sd_sum;
    logic              pend_valid;
    logic [DATA_W-1:0] pend_duty;

    always_comb begin
        strobe     = (state_q != IDLE) && (cnt_q == '0);
        period_end = (cnt_q == {DATA_W{1'b1}});
        sd_sum     = {1'b0, acc_q} + {1'b0, duty_q};
    end

    assign smp.sample_strobe = strobe;
    assign pwm_o             = pwm_q;
    assign active_o          = active_q;

    dac_scale #(
        .DATA_W (DATA_W),
        .GAIN_W (GAIN_W)
    ) u_scale (
        .clk      (clk),
        .rst_n    (rst_n),
        .valid_i  (strobe),
        .sample_i (smp.sample),
        .gain_i   (smp.gain),
        .valid_o  (pend_valid),
        .duty_o   (pend_duty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            duty_q   <= '0;
            pend_q   <= '0;
            acc_q    <= '0;
            mode_q   <= 1'b0;
            pwm_q    <= 1'b0;
            active_q <= 1'b0;
        end else begin
            if (pend_valid) begin
                pend_q <= pend_duty;
            end
            case (state_q)
                IDLE: begin
                    cnt_q  <= '0;
                    acc_q  <= '0;
                    duty_q <= '0;
                    pwm_q  <= 1'b0;
                    if (en_i) begin
                        state_q  <= RUN;
                        active_q <= 1'b1;
                    end
                end
                RUN, DRAIN: begin
                    cnt_q <= cnt_q + 1'b1;
                    acc_q <= sd_sum[DATA_W-1:0];
                    pwm_q <= mode_q ? sd_sum[DATA_W] : (cnt_q < duty_q);
                    if (period_end) begin
                        duty_q <= pend_q;
                        mode_q <= mode_i;
                    end
                    // Re-enable during DRAIN keeps the counter phase untouched.
                    if (en_i) begin
                        state_q <= RUN;
                    end else if (state_q == RUN) begin
                        state_q <= DRAIN;
                    end else if (period_end) begin
                        state_q  <= IDLE;
                        active_q <= 1'b0;
                        pwm_q    <= 1'b0;
                        acc_q    <= '0;
                        duty_q   <= '0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
